pc_gen: RTL

- Parametrised program-counter generator for the IF stage.
- Holds the fetch address and issues it to instruction memory over a req/ready handshake.
- Selects the next address from exception, branch or sequential sources.
- Latches redirects that arrive while fetch is stalled or not accepted, and traps misaligned fetch addresses.

---
 rtl/pc_gen.sv | 87 ++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program counter issuing fetch addresses over req/ready, with redirect latching and misaligned-fetch trap
//   clk/resetn        : clock, asynchronous active-low reset
//   stall             : hazard stall, blocks advance
//   except/except_addr: exception redirect
//   branch/branch_addr: branch/jump redirect
//   if_req/if_addr    : fetch request and address, if_ready accepts it
//   adel              : fetch address misaligned
//   redir_pend        : a latched redirect waits for the next advance
module pc_gen #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'hBFC0_0000,
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              except,
  input  logic [ADDR_W-1:0] except_addr,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              if_req,
  output logic [ADDR_W-1:0] if_addr,
  input  logic              if_ready,
  output logic              adel,
  output logic              redir_pend
);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, pend_addr, pend_addr_d;
  logic pend_valid, pend_valid_d, pend_is_exc, pend_is_exc_d;
  logic mis, advance, pend_exc;
  assign mis = |pc[1:0];
  assign if_addr = pc;
  assign if_req = state == RUN && !mis;
  assign adel = state != BOOT && mis;
  assign redir_pend = pend_valid;
  assign advance = if_req && if_ready && !stall;
  assign pend_exc = pend_valid && pend_is_exc;
  always_comb begin
    state_d = state;
    pc_d = pc;
    pend_valid_d = pend_valid;
    pend_is_exc_d = pend_is_exc;
    pend_addr_d = pend_addr;
    case (state)
      BOOT: state_d = RUN;
      RUN: begin
        state_d = mis ? FAULT : RUN;
        if (advance) begin
          pc_d = except ? except_addr : pend_valid ? pend_addr : branch ? branch_addr : pc + ADDR_W'(STEP);
          pend_valid_d = 1'b0;
        end else if (except) begin
          pend_valid_d = 1'b1;
          pend_is_exc_d = 1'b1;
          pend_addr_d = except_addr;
        end else if (branch && !pend_exc) begin
          pend_valid_d = 1'b1;
          pend_is_exc_d = 1'b0;
          pend_addr_d = branch_addr;
        end
      end
      FAULT: begin
        // only an exception (live or latched) can leave; latched branches are dropped
        state_d = (except || pend_exc) ? RUN : FAULT;
        pc_d = except ? except_addr : pend_exc ? pend_addr : pc;
        pend_valid_d = 1'b0;
        pend_is_exc_d = 1'b0;
      end
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= BOOT;
      pc <= RESET_VEC;
      pend_valid <= 1'b0;
      pend_is_exc <= 1'b0;
      pend_addr <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      pend_valid <= pend_valid_d;
      pend_is_exc <= pend_is_exc_d;
      pend_addr <= pend_addr_d;
    end
  end
endmodule
